// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and helpers for the sequential multiplier.
//               Holds the control state encoding and the iteration counter
//               width function.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cond_negate.sv
`default_nettype none
// ============================================================================
// Module      : cond_negate
// Description : Conditional two's-complement negator.
//               y = negate ? (~x + 1) : x
// Ports       : negate - 1 = return the two's complement of x
//               x      - WIDTH-bit input value
//               y      - WIDTH-bit output value
// Revision    : 1.0 - initial release
// ============================================================================
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic             negate,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  assign y = negate ? (~x + WIDTH'(1)) : x;

endmodule
`default_nettype wire

// File: rtl/seq_mult_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_mult_param
// Description : Parametrised sequential radix-2 shift-add multiplier with a
//               start/busy/done handshake and per-operation signed mode.
//               Operands are reduced to magnitudes on load, multiplied as
//               unsigned numbers, and the sign is restored in the FIX state.
// Ports       : clk       - system clock, rising edge
//               reset     - asynchronous reset, active low
//               start     - operation request, sampled only in IDLE
//               is_signed - 1 = two's-complement operands (sampled with start)
//               op_a      - multiplicand (sampled with start)
//               op_b      - multiplier (sampled with start)
//               busy      - high while in RUN or FIX
//               done      - one-cycle pulse when result is valid
//               result    - 2*WIDTH product, held until the next FIX edge
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mult_param
  import mult_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int EARLY_EXIT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int RES_W = 2 * WIDTH;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;

  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             neg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [RES_W-1:0] acc_fixed;
  logic [WIDTH-1:0] b_shifted;
  logic             last_iter;
  logic             b_empty;
  logic             load;
  logic             step;
  logic             finish;

  // Magnitude extraction. The most negative operand maps onto 2^(WIDTH-1),
  // which is representable as an unsigned WIDTH-bit value.
  cond_negate #(.WIDTH(WIDTH)) u_mag_a (
    .negate (is_signed & op_a[WIDTH-1]),
    .x      (op_a),
    .y      (mag_a)
  );

  cond_negate #(.WIDTH(WIDTH)) u_mag_b (
    .negate (is_signed & op_b[WIDTH-1]),
    .x      (op_b),
    .y      (mag_b)
  );

  // Sign restoration of the unsigned magnitude product.
  cond_negate #(.WIDTH(RES_W)) u_fix (
    .negate (neg),
    .x      (acc),
    .y      (acc_fixed)
  );

  assign b_shifted = b_sh >> 1;
  assign last_iter = (cnt == CNT_LAST);

  // Early exit looks at the multiplier after this edge's shift: once no set
  // bits remain, further iterations cannot change the accumulator.
  generate
    if (EARLY_EXIT != 0) begin : g_early_exit
      assign b_empty = (b_shifted == '0);
    end else begin : g_fixed_latency
      assign b_empty = 1'b0;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        // RUN always spends at least one edge here, even for a zero multiplier.
        if (last_iter || b_empty) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        busy      = 1'b1;
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= finish;
      if (load) begin
        acc  <= '0;
        a_sh <= {{WIDTH{1'b0}}, mag_a};
        b_sh <= mag_b;
        neg  <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        cnt  <= '0;
      end else if (step) begin
        // The magnitude product is below 2^(2*WIDTH), so this sum never carries out.
        if (b_sh[0]) begin
          acc <= acc + a_sh;
        end
        a_sh <= a_sh << 1;
        b_sh <= b_shifted;
        cnt  <= cnt + CNT_W'(1);
      end
      if (finish) begin
        result <= acc_fixed;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mult_param
// Description : Self-checking bench for seq_mult_param. Three instances share
//               one set of inputs: 8-bit with early exit, 8-bit fixed latency
//               and 32-bit with early exit. The 8-bit instances see the low
//               byte of each operand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mult_param;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        start     = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] op_a      = '0;
  logic [31:0] op_b      = '0;

  logic        busy8, done8, busy8f, done8f, busy32, done32;
  logic [15:0] result8, result8f;
  logic [63:0] result32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(8), .EARLY_EXIT(1)) dut8 (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .op_a(op_a[7:0]), .op_b(op_b[7:0]),
    .busy(busy8), .done(done8), .result(result8)
  );

  seq_mult_param #(.WIDTH(8), .EARLY_EXIT(0)) dut8f (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .op_a(op_a[7:0]), .op_b(op_b[7:0]),
    .busy(busy8f), .done(done8f), .result(result8f)
  );

  seq_mult_param #(.WIDTH(32), .EARLY_EXIT(1)) dut32 (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b),
    .busy(busy32), .done(done32), .result(result32)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [15:0] exp8;
    int          lat8;
    logic [63:0] exp32;
    int          lat32;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  // Results captured by run_op. lat* is the edge number (start edge = 1)
  // after which done was first seen high.
  logic [15:0] res8, res8f;
  logic [63:0] res32;
  int lat8, lat8f, lat32, busy8n, done8n;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One operation on all three instances. A non-zero poke pulses start with
  // unrelated operands for one cycle while the instances are busy.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int poke);
    lat8 = 0; lat8f = 0; lat32 = 0; busy8n = 0; done8n = 0;
    res8 = '1; res8f = '1; res32 = '1;
    @(negedge clk);
    op_a = a; op_b = b; is_signed = sgn; start = 1'b1;
    for (int e = 1; e <= 60; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        start = 1'b0; op_a = 32'hDEADBEEF; op_b = 32'h12345678; is_signed = ~sgn;
      end
      if (poke != 0 && e == poke) begin
        start = 1'b1; op_a = 32'h55; op_b = 32'h02; is_signed = 1'b1;
      end
      if (poke != 0 && e == poke + 1) start = 1'b0;
      if (busy8) busy8n++;
      if (done8) done8n++;
      if (done8  && lat8  == 0) begin lat8  = e; res8  = result8;  end
      if (done8f && lat8f == 0) begin lat8f = e; res8f = result8f; end
      if (done32 && lat32 == 0) begin lat32 = e; res32 = result32; end
      if (lat8 != 0 && lat8f != 0 && lat32 != 0) break;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           a             b             sgn   exp8      lat8 exp32                  lat32
    vecs[0]  = '{32'd3,        32'd5,        1'b0, 16'h000F, 5,   64'd15,                 5};
    vecs[1]  = '{32'h80,       32'h80,       1'b1, 16'h4000, 10,  64'h4000,               10};
    vecs[2]  = '{32'h80,       32'h01,       1'b1, 16'hFF80, 3,   64'h80,                 3};
    vecs[3]  = '{32'h80,       32'h01,       1'b0, 16'h0080, 3,   64'h80,                 3};
    vecs[4]  = '{32'hFF,       32'hFF,       1'b0, 16'hFE01, 10,  64'hFE01,               10};
    vecs[5]  = '{32'hAB,       32'h00,       1'b0, 16'h0000, 3,   64'h0,                  3};
    vecs[6]  = '{32'hF9,       32'h06,       1'b1, 16'hFFD6, 5,   64'h5D6,                5};
    vecs[7]  = '{32'd7,        32'd9,        1'b0, 16'h003F, 6,   64'h3F,                 6};
    vecs[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 16'hFE01, 10,  64'hFFFFFFFE00000001,   34};
    vecs[9]  = '{32'h80000000, 32'h80000000, 1'b1, 16'h0000, 3,   64'h4000000000000000,   34};
    vecs[10] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 16'h0000, 3,   64'h0000000080000000,   3};
    vecs[11] = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 16'hFFF1, 5,   64'hFFFFFFFFFFFFFFF1,   5};
    vecs[12] = '{32'h00000007, 32'hFFFFFFFA, 1'b1, 16'hFFD6, 5,   64'hFFFFFFFFFFFFFFD6,   5};
    vecs[13] = '{32'h00,       32'h80,       1'b1, 16'h0000, 10,  64'h0,                  10};
    vecs[14] = '{32'h85,       32'h00,       1'b1, 16'h0000, 3,   64'h0,                  3};

    // Reset state.
    #12;
    check("reset busy8", busy8, 1'b0);
    check("reset done8", done8, 1'b0);
    check("reset result8", result8, 16'h0);
    check("reset busy8f", busy8f, 1'b0);
    check("reset result32", result32, 64'h0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, 0);
      check($sformatf("v%0d res8", i), res8, vecs[i].exp8);
      check($sformatf("v%0d lat8", i), lat8, vecs[i].lat8);
      check($sformatf("v%0d busy8 cycles", i), busy8n, vecs[i].lat8 - 1);
      check($sformatf("v%0d done8 width", i), done8n, 1);
      check($sformatf("v%0d res8f", i), res8f, vecs[i].exp8);
      check($sformatf("v%0d lat8f", i), lat8f, 10);
      check($sformatf("v%0d res32", i), res32, vecs[i].exp32);
      check($sformatf("v%0d lat32", i), lat32, vecs[i].lat32);
      check($sformatf("v%0d hold8", i), result8, vecs[i].exp8);
    end

    // Start pulsed during RUN must be ignored.
    run_op(32'd3, 32'h81, 1'b0, 3);
    check("poke res8", res8, 16'h0183);
    check("poke lat8", lat8, 10);
    check("poke res32", res32, 64'h183);
    check("poke lat8f", lat8f, 10);
    @(negedge clk);
    check("poke idle8", busy8, 1'b0);

    // Back-to-back: start held high through done; second op taken on done cycle.
    @(negedge clk);
    op_a = 32'd7; op_b = 32'd9; is_signed = 1'b0; start = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        op_a = 32'h000000F9; op_b = 32'd6; is_signed = 1'b1;
      end
      if (e == 6) begin
        check("b2b done1", done8, 1'b1);
        check("b2b res1", result8, 16'h003F);
      end
      if (e == 7) begin
        start = 1'b0;
        check("b2b busy2", busy8, 1'b1);
        check("b2b done low", done8, 1'b0);
        check("b2b hold7", result8, 16'h003F);
      end
      if (e == 10) begin
        check("b2b hold10", result8, 16'h003F);
        check("b2b done10", done8, 1'b0);
      end
      if (e == 11) begin
        check("b2b done2", done8, 1'b1);
        check("b2b res2", result8, 16'hFFD6);
      end
    end
    repeat (50) @(posedge clk);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    op_a = 32'd7; op_b = 32'd9; is_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("midrun busy8 before", busy8, 1'b1);
    reset = 1'b0;
    #1;
    check("areset busy8", busy8, 1'b0);
    check("areset done8", done8, 1'b0);
    check("areset result8", result8, 16'h0);
    check("areset busy32", busy32, 1'b0);
    check("areset result32", result32, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("post reset done8", done8, 1'b0);
    check("post reset busy8", busy8, 1'b0);
    run_op(32'd7, 32'd9, 1'b0, 0);
    check("after reset res8", res8, 16'h003F);
    check("after reset lat8", lat8, 6);
    check("after reset res32", res32, 64'h3F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
